pong_engine_n: RTL

- Parametrised next-generation Pong game engine; advances game state one step per frame_clk pulse (one pulse every few VGA frames).
- Owns ball position/velocity, two paddle positions, scores and the game state machine.
- Outputs feed the position registers of the top level and the graphics block; the SSD shows state/scores.
- Generalises the fixed-geometry engine: canvas, sizes, speeds, score width, win score and serve delay are all parameters.

---
 rtl/pong_pkg.sv | 17 +
 rtl/paddle_ctrl.sv | 34 +++
 rtl/pong_engine_n.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong engine: state encoding, direction flags and
// {up,down} input bit positions.
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int unsigned UP   = 1;
  localparam int unsigned DOWN = 0;

endpackage

// File: rtl/paddle_ctrl.sv
// Paddle step: moves y by SPEED on a single up or down request, clamped to
// [MIN_Y, MAX_Y]; both or neither requested holds the position.
module paddle_ctrl #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned SPEED   = 4,
  parameter int unsigned MIN_Y   = 50,
  parameter int unsigned MAX_Y   = 400
) (
  input  logic               up,
  input  logic               down,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] next_y_c
);

  localparam int unsigned WW = COORD_W + 1;

  logic [WW-1:0] y_w;
  logic [WW-1:0] up_w;
  logic [WW-1:0] dn_w;

  // One extra bit keeps the step from wrapping before the clamp compare.
  always_comb begin
    y_w      = WW'(y);
    up_w     = y_w - WW'(SPEED);
    dn_w     = y_w + WW'(SPEED);
    next_y_c = y;
    if (up && !down) begin
      next_y_c = (y_w < WW'(MIN_Y + SPEED)) ? COORD_W'(MIN_Y) : COORD_W'(up_w);
    end else if (down && !up) begin
      next_y_c = (dn_w > WW'(MAX_Y)) ? COORD_W'(MAX_Y) : COORD_W'(dn_w);
    end
  end

endmodule

// File: rtl/pong_engine_n.sv
// Parametrised Pong game engine, one game step per frame_clk edge.
// Define PONG_AUTO_PADDLE_EN to make the left paddle track the ball on its own.
module pong_engine_n
  import pong_pkg::*;
#(
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned CANVAS_TOP    = 50,
  parameter int unsigned CANVAS_BOTTOM = 450,
  parameter int unsigned CANVAS_LEFT   = 50,
  parameter int unsigned CANVAS_RIGHT  = 600,
  parameter int unsigned BALL_SIZE     = 10,
  parameter int unsigned PADDLE_OFFSET = 20,
  parameter int unsigned PADDLE_HEIGHT = 50,
  parameter int unsigned PADDLE_WIDTH  = 10,
  parameter int unsigned PADDLE_SPEED  = 4,
  parameter int unsigned BALL_SPEED    = 2,
  parameter int unsigned WIN_SCORE     = 9,
  parameter int unsigned SERVE_FRAMES  = 60
) (
  input  logic               frame_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         left_in,
  input  logic [1:0]         right_in,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_l,
  output logic [COORD_W-1:0] paddle_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               running,
  output logic               game_over
);

  localparam int unsigned WW     = COORD_W + 1;
  localparam int unsigned CNT_W  = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned CX     = (CANVAS_LEFT + CANVAS_RIGHT - BALL_SIZE) / 2;
  localparam int unsigned CY     = (CANVAS_TOP + CANVAS_BOTTOM - BALL_SIZE) / 2;
  localparam int unsigned PC     = (CANVAS_TOP + CANVAS_BOTTOM - PADDLE_HEIGHT) / 2;
  localparam int unsigned P_MAX  = CANVAS_BOTTOM - PADDLE_HEIGHT;
  localparam int unsigned FACE_R = CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH;
  localparam int unsigned FACE_L = CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH;

  logic               l_up, l_down;
  logic [COORD_W-1:0] pl_step_c, pr_step_c;

`ifdef PONG_AUTO_PADDLE_EN
  localparam int unsigned L_SPEED = PADDLE_SPEED / 2;
  logic [WW-1:0] pl_mid, ball_mid;
  // Dead band of +/-2 px around the ball centre keeps the paddle from jittering.
  assign pl_mid   = WW'(paddle_l) + WW'(PADDLE_HEIGHT / 2);
  assign ball_mid = WW'(ball_y) + WW'(BALL_SIZE / 2);
  assign l_down   = (pl_mid + WW'(2)) < ball_mid;
  assign l_up     = pl_mid > (ball_mid + WW'(2));
`else
  localparam int unsigned L_SPEED = PADDLE_SPEED;
  assign l_up   = left_in[UP];
  assign l_down = left_in[DOWN];
`endif

  paddle_ctrl #(
    .COORD_W(COORD_W), .SPEED(L_SPEED), .MIN_Y(CANVAS_TOP), .MAX_Y(P_MAX)
  ) u_paddle_l (
    .up(l_up), .down(l_down), .y(paddle_l), .next_y_c(pl_step_c)
  );

  paddle_ctrl #(
    .COORD_W(COORD_W), .SPEED(PADDLE_SPEED), .MIN_Y(CANVAS_TOP), .MAX_Y(P_MAX)
  ) u_paddle_r (
    .up(right_in[UP]), .down(right_in[DOWN]), .y(paddle_r), .next_y_c(pr_step_c)
  );

  logic               dir_x, dir_y, scorer_l;
  logic [CNT_W-1:0]   serve_cnt;

  logic [2:0]         state_nxt;
  logic [COORD_W-1:0] bx_nxt, by_nxt, pl_nxt, pr_nxt;
  logic [SCORE_W-1:0] sl_nxt, sr_nxt, s_inc;
  logic               dx_nxt, dy_nxt, scorer_nxt, running_nxt, over_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [WW-1:0]      bx_w, by_w, nx, ny;
  logic               ovl_l, ovl_r;

  // Next-state and datapath update for one game step.
  always_comb begin
    state_nxt  = state;
    bx_nxt     = ball_x;
    by_nxt     = ball_y;
    pl_nxt     = paddle_l;
    pr_nxt     = paddle_r;
    sl_nxt     = score_l;
    sr_nxt     = score_r;
    dx_nxt     = dir_x;
    dy_nxt     = dir_y;
    cnt_nxt    = serve_cnt;
    scorer_nxt = scorer_l;
    s_inc      = '0;

    bx_w  = WW'(ball_x);
    by_w  = WW'(ball_y);
    nx    = (dir_x == DIR_POS) ? bx_w + WW'(BALL_SPEED) : bx_w - WW'(BALL_SPEED);
    ny    = (dir_y == DIR_POS) ? by_w + WW'(BALL_SPEED) : by_w - WW'(BALL_SPEED);
    ovl_r = (by_w + WW'(BALL_SIZE) > WW'(paddle_r)) &&
            (by_w < WW'(paddle_r) + WW'(PADDLE_HEIGHT));
    ovl_l = (by_w + WW'(BALL_SIZE) > WW'(paddle_l)) &&
            (by_w < WW'(paddle_l) + WW'(PADDLE_HEIGHT));

    case (state)
      ST_IDLE: begin
        bx_nxt = COORD_W'(CX);
        by_nxt = COORD_W'(CY);
        pl_nxt = COORD_W'(PC);
        pr_nxt = COORD_W'(PC);
        if (start) begin
          sl_nxt    = '0;
          sr_nxt    = '0;
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (start) begin
          pl_nxt = pl_step_c;
          pr_nxt = pr_step_c;
          if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_PLAY;
          end else begin
            cnt_nxt = serve_cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (start) begin
          pl_nxt = pl_step_c;
          pr_nxt = pr_step_c;
          // Vertical: walls
          if (dir_y == DIR_POS && ny + WW'(BALL_SIZE) >= WW'(CANVAS_BOTTOM)) begin
            by_nxt = COORD_W'(CANVAS_BOTTOM - BALL_SIZE);
            dy_nxt = DIR_NEG;
          end else if (dir_y == DIR_NEG && ny <= WW'(CANVAS_TOP)) begin
            by_nxt = COORD_W'(CANVAS_TOP);
            dy_nxt = DIR_POS;
          end else begin
            by_nxt = COORD_W'(ny);
          end
          // Horizontal: paddle face first, then the goal line behind it
          if (dir_x == DIR_POS) begin
            if (nx + WW'(BALL_SIZE) >= WW'(FACE_R) &&
                bx_w + WW'(BALL_SIZE) <= WW'(FACE_R) && ovl_r) begin
              bx_nxt = COORD_W'(FACE_R - BALL_SIZE);
              dx_nxt = DIR_NEG;
            end else begin
              bx_nxt = COORD_W'(nx);
              if (nx + WW'(BALL_SIZE) >= WW'(CANVAS_RIGHT)) begin
                scorer_nxt = 1'b1;
                state_nxt  = ST_POINT;
              end
            end
          end else begin
            if (nx <= WW'(FACE_L) && bx_w >= WW'(FACE_L) && ovl_l) begin
              bx_nxt = COORD_W'(FACE_L);
              dx_nxt = DIR_POS;
            end else begin
              bx_nxt = COORD_W'(nx);
              if (nx <= WW'(CANVAS_LEFT)) begin
                scorer_nxt = 1'b0;
                state_nxt  = ST_POINT;
              end
            end
          end
        end
      end
      ST_POINT: begin
        if (scorer_l) begin
          s_inc  = (score_l >= SCORE_W'(WIN_SCORE)) ? SCORE_W'(WIN_SCORE) : score_l + SCORE_W'(1);
          sl_nxt = s_inc;
        end else begin
          s_inc  = (score_r >= SCORE_W'(WIN_SCORE)) ? SCORE_W'(WIN_SCORE) : score_r + SCORE_W'(1);
          sr_nxt = s_inc;
        end
        if (s_inc == SCORE_W'(WIN_SCORE)) begin
          state_nxt = ST_OVER;
        end else begin
          state_nxt = ST_SERVE;
          bx_nxt    = COORD_W'(CX);
          by_nxt    = COORD_W'(CY);
          // Serve toward whoever just conceded.
          dx_nxt    = scorer_l ? DIR_POS : DIR_NEG;
        end
      end
      ST_OVER: begin
        if (!start) begin
          state_nxt = ST_IDLE;
          bx_nxt    = COORD_W'(CX);
          by_nxt    = COORD_W'(CY);
          pl_nxt    = COORD_W'(PC);
          pr_nxt    = COORD_W'(PC);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    running_nxt = ((state_nxt == ST_SERVE) || (state_nxt == ST_PLAY)) && start;
    over_nxt    = (state_nxt == ST_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ball_x    <= COORD_W'(CX);
      ball_y    <= COORD_W'(CY);
      paddle_l  <= COORD_W'(PC);
      paddle_r  <= COORD_W'(PC);
      score_l   <= '0;
      score_r   <= '0;
      dir_x     <= DIR_POS;
      dir_y     <= DIR_POS;
      serve_cnt <= '0;
      scorer_l  <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      ball_x    <= bx_nxt;
      ball_y    <= by_nxt;
      paddle_l  <= pl_nxt;
      paddle_r  <= pr_nxt;
      score_l   <= sl_nxt;
      score_r   <= sr_nxt;
      dir_x     <= dx_nxt;
      dir_y     <= dy_nxt;
      serve_cnt <= cnt_nxt;
      scorer_l  <= scorer_nxt;
      running   <= running_nxt;
      game_over <= over_nxt;
    end
  end

endmodule
